// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM encodings, default word width and bus-mode
// constants common to the 8-bit master and this slave receiver.
package spi_pkg;

    localparam int   SPI_DATA_W         = 8;
    localparam logic SPI_CPOL           = 1'b1;
    localparam logic SPI_SAMPLE_ON_FALL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } spi_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI bus wires between the link master and the slave receiver.
interface spi_slave_rx_if;
    logic spi_clk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output spi_clk, output cs, output mosi, input miso);
    modport slave  (input spi_clk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with history flop; emits the delayed level and
// registered single-cycle rise/fall pulses aligned with that level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchroniser chain, history flop and registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= ~hist_q &  sync_q[SYNC_STAGES-1];
            fall_q <=  hist_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = hist_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (CPOL=1, sample on falling spi_clk), MSB-first words.
// Optional MISO transmit path enabled with `define SPI_SLAVE_MISO_EN.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_slave_rx_if.slave     spi,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] data_rd,
    output logic              data_valid,
    output logic              frame_err,
    output logic [7:0]        byte_cnt,
    output logic [1:0]        state
);

    localparam int            CW   = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic sample_s, drive_s, mosi_s, unused_s;

    logic [SYNC_STAGES:0] mosi_q;

    spi_state_e        state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nxt_s;
    logic [DATA_W-1:0] data_rd_q, data_rd_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              pend_q, pend_d;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi.spi_clk),
        .level_o (sclk_lvl_s),
        .rise_o  (sclk_rise_s),
        .fall_o  (sclk_fall_s)
    );

    // cs resets as "asserted" so a frame already running across reset yields no cs_fall.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi.cs),
        .level_o (cs_lvl_s),
        .rise_o  (cs_rise_s),
        .fall_o  (cs_fall_s)
    );

    // mosi gets one extra stage to line up with the registered spi_clk edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], spi.mosi};
        end
    end

    assign mosi_s      = mosi_q[SYNC_STAGES];
    assign sample_s    = SPI_SAMPLE_ON_FALL ? sclk_fall_s : sclk_rise_s;
    assign drive_s     = SPI_SAMPLE_ON_FALL ? sclk_rise_s : sclk_fall_s;
    assign shift_nxt_s = {shift_q[DATA_W-2:0], mosi_s};

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic              miso_q, miso_d;

    assign spi.miso = miso_q;
    assign unused_s = sclk_lvl_s;
`else
    assign spi.miso = 1'b1;
    assign unused_s = ^{tx_data, drive_s, sclk_lvl_s};
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_rd_q  <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            byte_cnt_q <= 8'd0;
            pend_q     <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
            tx_q       <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_rd_q  <= data_rd_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            byte_cnt_q <= byte_cnt_d;
            pend_q     <= pend_d;
`ifdef SPI_SLAVE_MISO_EN
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            miso_q     <= miso_d;
`endif
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_rd_d  = data_rd_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        byte_cnt_d = byte_cnt_q;
        pend_d     = pend_q;
`ifdef SPI_SLAVE_MISO_EN
        tx_d       = tx_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = miso_q;
`endif
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
`ifdef SPI_SLAVE_MISO_EN
                miso_d = 1'b1;
`endif
                if (cs_fall_s || (pend_q && !cs_lvl_s)) begin
                    state_d    = RECV;
                    bit_cnt_d  = '0;
                    byte_cnt_d = 8'd0;
`ifdef SPI_SLAVE_MISO_EN
                    tx_d       = tx_data;
                    tx_cnt_d   = '0;
                    miso_d     = tx_data[DATA_W-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (sample_s) begin
                    shift_d = shift_nxt_s;
                    if (bit_cnt_q == LAST) begin
                        data_rd_d  = shift_nxt_s;
                        valid_d    = 1'b1;
                        byte_cnt_d = sat_inc8(byte_cnt_q);
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else begin
                    shift_d = shift_q;
                end
`ifdef SPI_SLAVE_MISO_EN
                if (drive_s) begin
                    if (tx_cnt_q == LAST) begin
                        tx_d     = tx_data;
                        tx_cnt_d = '0;
                        miso_d   = tx_data[DATA_W-1];
                    end else begin
                        tx_d     = {tx_q[DATA_W-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + CW'(1);
                        miso_d   = tx_q[DATA_W-2];
                    end
                end else begin
                    tx_d = tx_q;
                end
`endif
                // A word completing in the same cycle as cs_rise leaves bit_cnt_d at 0: no error.
                if (cs_rise_s) begin
                    state_d = DONE;
                    if (bit_cnt_d != '0) begin
                        ferr_d    = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        ferr_d = 1'b0;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SPI_SLAVE_MISO_EN
                miso_d  = 1'b1;
`endif
                if (cs_fall_s) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_rd    = data_rd_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign byte_cnt   = byte_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: bit-banged SPI master plus a
// scoreboard of expected words checked whenever data_valid strobes.
module tb_spi_slave_rx;

    localparam int LAT = 4;  // SYNC_STAGES (2) + 2

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic [7:0] data_rd;
    logic       data_valid;
    logic       frame_err;
    logic [7:0] byte_cnt;
    logic [1:0] state;

    spi_slave_rx_if sif();

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (sif),
        .tx_data    (tx_data),
        .data_rd    (data_rd),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .byte_cnt   (byte_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   fall8_cyc = 0;
    int   valid_seen = 0;
    int   ferr_seen  = 0;

    function automatic logic [7:0] miso_expect();
`ifdef SPI_SLAVE_MISO_EN
        return tx_data;
`else
        return 8'hFF;
`endif
    endfunction

    // Advance one clock, sampling at the falling edge; scoreboard compare on data_valid.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (frame_err === 1'b1) ferr_seen++;
        if (data_valid === 1'b1) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: data_rd=%h byte_cnt=%0d, no word expected", data_rd, byte_cnt);
            end else begin
                e = exp_q.pop_front();
                if ({data_rd, byte_cnt} !== {e.data, e.cnt}) begin
                    errors++;
                    $display("FAIL word: data_rd=%h byte_cnt=%0d, expected %h / %0d", data_rd, byte_cnt, e.data, e.cnt);
                end
                checks++;
                if (cyc - fall8_cyc !== LAT) begin
                    errors++;
                    $display("FAIL latency: %0d cycles, expected %0d", cyc - fall8_cyc, LAT);
                end
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input logic [7:0] cnt_exp,
                             input bit cs_on_last, output logic [7:0] cap);
        cap = 8'h00;
        if (nbits == 8) exp_q.push_back({b, cnt_exp});
        for (int i = 7; i >= 8 - nbits; i--) begin
            sif.mosi = b[i];
            repeat (2) tick();
            sif.spi_clk = 1'b0;
            if (i == 0) fall8_cyc = cyc;
            if (cs_on_last && i == 8 - nbits) sif.cs = 1'b1;
            repeat (2) tick();
            cap[i] = sif.miso;
            sif.spi_clk = 1'b1;
        end
    endtask

    task automatic begin_frame();
        sif.cs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic end_frame();
        repeat (2) tick();
        sif.cs = 1'b1;
        repeat (8) tick();
    endtask

    task automatic check_pending(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d words never delivered, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state, data_rd, data_valid, frame_err, byte_cnt, sif.miso} !== {2'd0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: state=%0d data_rd=%h valid=%b ferr=%b byte_cnt=%0d miso=%b",
                     state, data_rd, data_valid, frame_err, byte_cnt, sif.miso);
        end
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d, expected 0", state);
        end
    endtask

    task automatic test_single();
        logic [7:0] cap;
        int v0 = valid_seen, f0 = ferr_seen;
        tx_data = 8'h00;
        begin_frame();
        send_bits(8'hA5, 8, 8'd1, 1'b0, cap);
        end_frame();
        check_pending("single");
        checks++;
        if ({valid_seen - v0, ferr_seen - f0} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL single_strobes: valid=%0d ferr=%0d, expected 1/0", valid_seen - v0, ferr_seen - f0);
        end
        checks++;
        if ({data_rd, byte_cnt, state} !== {8'hA5, 8'd1, 2'd0}) begin
            errors++;
            $display("FAIL single_hold: data_rd=%h byte_cnt=%0d state=%0d, expected a5/1/0", data_rd, byte_cnt, state);
        end
        checks++;
        if (cap !== miso_expect()) begin
            errors++;
            $display("FAIL single_miso: got %h, expected %h", cap, miso_expect());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap;
        int v0 = valid_seen;
        begin_frame();
        send_bits(8'h3C, 8, 8'd1, 1'b0, cap);
        send_bits(8'hC3, 8, 8'd2, 1'b0, cap);
        checks++;
        if (cap !== miso_expect()) begin
            errors++;
            $display("FAIL b2b_miso: got %h, expected %h", cap, miso_expect());
        end
        end_frame();
        check_pending("b2b");
        checks++;
        if ({valid_seen - v0, data_rd, byte_cnt} !== {32'd2, 8'hC3, 8'd2}) begin
            errors++;
            $display("FAIL b2b_final: valid=%0d data_rd=%h byte_cnt=%0d, expected 2/c3/2", valid_seen - v0, data_rd, byte_cnt);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] cap;
        int v0 = valid_seen, f0 = ferr_seen;
        begin_frame();
        send_bits(8'hFF, 5, 8'd0, 1'b0, cap);
        end_frame();
        checks++;
        if ({valid_seen - v0, ferr_seen - f0} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL ferr_strobes: valid=%0d ferr=%0d, expected 0/1", valid_seen - v0, ferr_seen - f0);
        end
        checks++;
        if ({data_rd, byte_cnt, state} !== {8'hC3, 8'd0, 2'd0}) begin
            errors++;
            $display("FAIL ferr_hold: data_rd=%h byte_cnt=%0d state=%0d, expected c3/0/0", data_rd, byte_cnt, state);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] cap;
        int v0, f0;
        begin_frame();
        send_bits(8'hF0, 4, 8'd0, 1'b0, cap);
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state, data_rd, data_valid, frame_err, byte_cnt, sif.miso} !== {2'd0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_values: state=%0d data_rd=%h valid=%b ferr=%b byte_cnt=%0d miso=%b",
                     state, data_rd, data_valid, frame_err, byte_cnt, sif.miso);
        end
        reset = 1'b0;
        v0 = valid_seen;
        f0 = ferr_seen;
        tick();
        send_bits(8'hF0, 4, 8'd0, 1'b0, cap);
        end_frame();
        checks++;
        if ({valid_seen - v0, ferr_seen - f0, state, data_rd} !== {32'd0, 32'd0, 2'd0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_ignored: valid=%0d ferr=%0d state=%0d data_rd=%h, expected 0/0/0/00",
                     valid_seen - v0, ferr_seen - f0, state, data_rd);
        end
        begin_frame();
        send_bits(8'h81, 8, 8'd1, 1'b0, cap);
        end_frame();
        check_pending("midreset");
        checks++;
        if ({data_rd, byte_cnt} !== {8'h81, 8'd1}) begin
            errors++;
            $display("FAIL midreset_after: data_rd=%h byte_cnt=%0d, expected 81/1", data_rd, byte_cnt);
        end
    endtask

    task automatic test_cs_with_last_fall();
        logic [7:0] cap;
        int v0 = valid_seen, f0 = ferr_seen;
        begin_frame();
        send_bits(8'h6B, 8, 8'd1, 1'b1, cap);
        repeat (8) tick();
        check_pending("simul");
        checks++;
        if ({valid_seen - v0, ferr_seen - f0, data_rd, state} !== {32'd1, 32'd0, 8'h6B, 2'd0}) begin
            errors++;
            $display("FAIL simul: valid=%0d ferr=%0d data_rd=%h state=%0d, expected 1/0/6b/0",
                     valid_seen - v0, ferr_seen - f0, data_rd, state);
        end
    endtask

    task automatic test_idle_clk();
        int v0 = valid_seen, f0 = ferr_seen;
        int bad = 0;
        sif.cs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sif.mosi = i[0];
            sif.spi_clk = 1'b0;
            repeat (2) tick();
            sif.spi_clk = 1'b1;
            repeat (2) tick();
            if (state !== 2'd0) bad++;
        end
        repeat (4) tick();
        checks++;
        if ({bad, valid_seen - v0, ferr_seen - f0, sif.miso} !== {32'd0, 32'd0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL idle_clk: non-idle samples=%0d valid=%0d ferr=%0d miso=%b, expected 0/0/0/1",
                     bad, valid_seen - v0, ferr_seen - f0, sif.miso);
        end
    endtask

`ifdef SPI_SLAVE_MISO_EN
    task automatic test_miso();
        logic [7:0] cap;
        tx_data = 8'h5A;
        begin_frame();
        send_bits(8'h00, 8, 8'd1, 1'b0, cap);
        end_frame();
        check_pending("miso");
        checks++;
        if ({cap, data_rd, sif.miso} !== {8'h5A, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL miso_tx: captured=%h data_rd=%h idle_miso=%b, expected 5a/00/1", cap, data_rd, sif.miso);
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        tx_data     = 8'h00;
        sif.cs      = 1'b1;
        sif.spi_clk = 1'b1;
        sif.mosi    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_frame();
        test_cs_with_last_fall();
        test_idle_clk();
`ifdef SPI_SLAVE_MISO_EN
        test_miso();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
